// File: rtl/i2c_banked_memory_writer.sv
// Write-only I2C target that streams received bytes into one of NUM_BANKS memories.
// Define I2C_MEM_WRITER_ADDR_PTR_EN to add a start-address byte after the bank byte.
module i2c_banked_memory_writer #(
  parameter logic [6:0]   DEVICE_ADDRESS = 7'h7F,
  parameter int unsigned  NUM_BANKS      = 2,
  parameter int unsigned  DEPTH          = 256,
  parameter int unsigned  SYNC_STAGES    = 2,
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              copi_scl,
  input  logic              copi_sda,
  output logic              cipo_scl,
  output logic              cipo_sda,
  output logic              write_active,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren
);

  typedef enum logic [2:0] {
    IDLE,
    DEV_ADR,
    BANK,
`ifdef I2C_MEM_WRITER_ADDR_PTR_EN
    PTR,
`endif
    FILL
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   start, stop, scl_rise, scl_fall;

  logic [3:0]        cnt, cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              ack_n;
  logic [BANK_W-1:0] bank_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;
  logic              wren_n;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign start    = scl_s && scl_prev && sda_prev && !sda_s;
  assign stop     = scl_s && scl_prev && !sda_prev && sda_s;
  assign scl_rise = scl_s && !scl_prev;
  assign scl_fall = !scl_s && scl_prev;

  assign cipo_scl     = 1'b1;
  assign write_active = (state == FILL);

  // Synchroniser and edge-detect flops idle high so reset never fakes a START/STOP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], copi_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], copi_sda};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      cipo_sda  <= 1'b1;
      mem_bank  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      cipo_sda  <= ack_n;
      mem_bank  <= bank_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_wren  <= wren_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    ack_n   = cipo_sda;
    bank_n  = mem_bank;
    // Address advances the clock after each strobe, whatever else happens that cycle.
    addr_n  = mem_wren ? mem_addr + ADDR_W'(1) : mem_addr;
    wdata_n = mem_wdata;
    wren_n  = 1'b0;

    if (start) begin
      state_n = DEV_ADR;
      cnt_n   = '0;
      shreg_n = '0;
      ack_n   = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      ack_n   = 1'b1;
    end else if (state != IDLE) begin
      if (scl_rise) begin
        if (cnt <= 4'd7) shreg_n[3'd7 - cnt[2:0]] = sda_s;
        cnt_n = cnt + 4'd1;
      end else if (scl_fall) begin
        if (cnt == 4'd8) begin
          case (state)
            DEV_ADR:
              if (shreg == {DEVICE_ADDRESS, 1'b0}) ack_n = 1'b0;
              else state_n = IDLE;
            BANK:
              if (32'(shreg) < NUM_BANKS) begin
                ack_n  = 1'b0;
                bank_n = BANK_W'(shreg);
                addr_n = '0;
              end else begin
                state_n = IDLE;
              end
`ifdef I2C_MEM_WRITER_ADDR_PTR_EN
            PTR:
              if (32'(shreg) < DEPTH) begin
                ack_n  = 1'b0;
                addr_n = ADDR_W'(shreg);
              end else begin
                state_n = IDLE;
              end
`endif
            FILL: begin
              ack_n   = 1'b0;
              wdata_n = shreg;
              wren_n  = 1'b1;
            end
            default: ;
          endcase
        end else if (cnt == 4'd9) begin
          ack_n   = 1'b1;
          cnt_n   = '0;
          shreg_n = '0;
          case (state)
            DEV_ADR: state_n = BANK;
`ifdef I2C_MEM_WRITER_ADDR_PTR_EN
            BANK:    state_n = PTR;
            PTR:     state_n = FILL;
`else
            BANK:    state_n = FILL;
`endif
            default: ;
          endcase
        end else if (cnt >= 4'd10) begin
          state_n = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_banked_memory_writer.sv
// Randomised bench: a default-size writer and a DEPTH=4 writer share one I2C bus,
// each checked against a byte-level model of the transaction rules.
module tb_i2c_banked_memory_writer;

  localparam int Q       = 6;
  localparam int ACK_CYC = 3 * Q;
`ifdef I2C_MEM_WRITER_ADDR_PTR_EN
  localparam bit PTR_EN = 1'b1;
`else
  localparam bit PTR_EN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic scl     = 1'b1;
  logic sda     = 1'b1;

  always #5 clock = ~clock;

  logic       b_cipo_scl, b_cipo_sda, b_active, b_wren;
  logic [0:0] b_bank;
  logic [7:0] b_addr, b_wdata;
  logic       s_cipo_scl, s_cipo_sda, s_active, s_wren;
  logic [0:0] s_bank;
  logic [1:0] s_addr;
  logic [7:0] s_wdata;

  i2c_banked_memory_writer u_big (
    .clock(clock), .reset_n(reset_n), .copi_scl(scl), .copi_sda(sda),
    .cipo_scl(b_cipo_scl), .cipo_sda(b_cipo_sda), .write_active(b_active),
    .mem_bank(b_bank), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wren(b_wren)
  );

  i2c_banked_memory_writer #(.DEPTH(4)) u_small (
    .clock(clock), .reset_n(reset_n), .copi_scl(scl), .copi_sda(sda),
    .cipo_scl(s_cipo_scl), .cipo_sda(s_cipo_sda), .write_active(s_active),
    .mem_bank(s_bank), .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_wren(s_wren)
  );

  logic [1:0] cipo_v, cscl_v, active_v, wren_v, bank_v;
  logic [7:0] addr_v [2];
  logic [7:0] wdata_v [2];

  assign cipo_v    = {s_cipo_sda, b_cipo_sda};
  assign cscl_v    = {s_cipo_scl, b_cipo_scl};
  assign active_v  = {s_active, b_active};
  assign wren_v    = {s_wren, b_wren};
  assign bank_v    = {s_bank, b_bank};
  assign addr_v[0] = b_addr;
  assign addr_v[1] = {6'd0, s_addr};
  assign wdata_v[0] = b_wdata;
  assign wdata_v[1] = s_wdata;

  int unsigned low_cnt [2] = '{0, 0};
  int unsigned wren_cnt[2] = '{0, 0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!cipo_v[i]) low_cnt[i]++;
      if (wren_v[i])  wren_cnt[i]++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte position within a transaction decides its meaning.
  int          depth_v[2] = '{256, 4};
  int          m_bank[2]  = '{0, 0};
  int          m_ptr[2]   = '{0, 0};
  bit          m_alive[2];
  int          m_acks[2];
  int          m_writes[2];
  int          m_idx;
  int unsigned snap_low[2];
  int unsigned snap_wr[2];
  logic [7:0]  tx_q[$];

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    sda = 1'b1; wait_clks(Q);
    scl = 1'b1; wait_clks(Q);
    sda = 1'b0; wait_clks(Q);
    scl = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; wait_clks(Q);
    scl = 1'b1; wait_clks(Q);
    sda = 1'b1; wait_clks(Q);
  endtask

  task automatic txn_begin();
    bus_start();
    m_idx = 0;
    for (int i = 0; i < 2; i++) begin
      m_alive[i]  = 1'b1;
      m_acks[i]   = 0;
      m_writes[i] = 0;
      snap_low[i] = low_cnt[i];
      snap_wr[i]  = wren_cnt[i];
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rst_in_ack);
    bit exp_ack[2];
    bit exp_wr[2];
    int fill_idx;
    fill_idx = PTR_EN ? 3 : 2;
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = 1'b0;
      exp_wr[i]  = 1'b0;
      if (m_alive[i]) begin
        if (m_idx == 0)                exp_ack[i] = (v == 8'hFE);
        else if (m_idx == 1)           exp_ack[i] = (int'(v) < 2);
        else if (m_idx == 2 && PTR_EN) exp_ack[i] = (int'(v) < depth_v[i]);
        else begin
          exp_ack[i] = 1'b1;
          exp_wr[i]  = 1'b1;
        end
      end
    end
    for (int b = 7; b >= 0; b--) begin
      sda = v[b]; wait_clks(Q);
      scl = 1'b1; wait_clks(2 * Q);
      scl = 1'b0;
      if (b != 0) wait_clks(Q);
    end
    sda = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 2; i++) check_eq($sformatf("wren_early%0d", i), wren_v[i], 0);
    wait_clks(1);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("wren%0d", i), wren_v[i], exp_wr[i]);
      if (exp_wr[i]) begin
        check_eq($sformatf("waddr%0d", i), addr_v[i], m_ptr[i]);
        check_eq($sformatf("wdata%0d", i), wdata_v[i], v);
        check_eq($sformatf("wbank%0d", i), bank_v[i], m_bank[i]);
      end
    end
    wait_clks(1);
    for (int i = 0; i < 2; i++) check_eq($sformatf("wren_late%0d", i), wren_v[i], 0);
    wait_clks(Q - 4);
    scl = 1'b1; wait_clks(Q);
    for (int i = 0; i < 2; i++) check_eq($sformatf("ack%0d", i), cipo_v[i], !exp_ack[i]);
    if (rst_in_ack) begin
      for (int i = 0; i < 2; i++)
        check_eq($sformatf("active_pre_rst%0d", i), active_v[i], m_alive[i] && m_idx >= fill_idx);
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        check_eq($sformatf("rst_cipo%0d", i),   cipo_v[i],   1);
        check_eq($sformatf("rst_active%0d", i), active_v[i], 0);
        check_eq($sformatf("rst_wren%0d", i),   wren_v[i],   0);
        check_eq($sformatf("rst_bank%0d", i),   bank_v[i],   0);
        check_eq($sformatf("rst_addr%0d", i),   addr_v[i],   0);
        check_eq($sformatf("rst_wdata%0d", i),  wdata_v[i],  0);
        m_bank[i]  = 0;
        m_ptr[i]   = 0;
        m_alive[i] = 1'b0;
      end
      wait_clks(2);
      reset_n = 1'b1;
      wait_clks(Q);
      scl = 1'b0; wait_clks(Q);
      return;
    end
    wait_clks(Q);
    scl = 1'b0; wait_clks(Q);
    for (int i = 0; i < 2; i++) begin
      if (m_alive[i]) begin
        if (!exp_ack[i]) m_alive[i] = 1'b0;
        else begin
          m_acks[i]++;
          if (m_idx == 1) begin
            m_bank[i] = int'(v);
            m_ptr[i]  = 0;
          end else if (m_idx == 2 && PTR_EN) begin
            m_ptr[i] = int'(v);
          end else if (exp_wr[i]) begin
            m_writes[i]++;
            m_ptr[i] = (m_ptr[i] + 1) % depth_v[i];
          end
        end
      end
    end
    m_idx++;
  endtask

  task automatic run_txn(input bit stop_end, input int partial);
    int fill_idx;
    fill_idx = PTR_EN ? 3 : 2;
    txn_begin();
    foreach (tx_q[k]) send_byte(tx_q[k], 1'b0);
    for (int b = 0; b < partial; b++) begin
      sda = 1'($urandom_range(0, 1)); wait_clks(Q);
      scl = 1'b1; wait_clks(2 * Q);
      scl = 1'b0; wait_clks(Q);
    end
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("active%0d", i), active_v[i], m_alive[i] && m_idx >= fill_idx);
    if (stop_end) bus_stop();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ack_cycles%0d", i), low_cnt[i] - snap_low[i], ACK_CYC * m_acks[i]);
      check_eq($sformatf("wren_pulses%0d", i), wren_cnt[i] - snap_wr[i], m_writes[i]);
      check_eq($sformatf("bank%0d", i), bank_v[i], m_bank[i]);
      check_eq($sformatf("addr%0d", i), addr_v[i], m_ptr[i]);
      if (stop_end) check_eq($sformatf("active_stop%0d", i), active_v[i], 0);
    end
  endtask

  task automatic hdr(input logic [7:0] bank);
    tx_q.delete();
    tx_q.push_back(8'hFE);
    tx_q.push_back(bank);
    if (PTR_EN) tx_q.push_back(8'h00);
  endtask

  initial begin
    bit         bus_open;
    bit         stop_end;
    logic [7:0] t;

    reset_n = 1'b0;
    wait_clks(3);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("reset_cipo%0d", i),   cipo_v[i],   1);
      check_eq($sformatf("reset_cscl%0d", i),   cscl_v[i],   1);
      check_eq($sformatf("reset_active%0d", i), active_v[i], 0);
      check_eq($sformatf("reset_wren%0d", i),   wren_v[i],   0);
      check_eq($sformatf("reset_bank%0d", i),   bank_v[i],   0);
      check_eq($sformatf("reset_addr%0d", i),   addr_v[i],   0);
      check_eq($sformatf("reset_wdata%0d", i),  wdata_v[i],  0);
    end
    reset_n = 1'b1;
    wait_clks(4);

    hdr(8'h01); tx_q.push_back(8'hAA); tx_q.push_back(8'h55); run_txn(1'b1, 0);
    tx_q.delete(); tx_q.push_back(8'hFC); tx_q.push_back(8'h00); run_txn(1'b1, 0);
    tx_q.delete(); tx_q.push_back(8'hFF); tx_q.push_back(8'h00); run_txn(1'b1, 0);
    tx_q.delete(); tx_q.push_back(8'hFE); tx_q.push_back(8'h02); tx_q.push_back(8'h00); run_txn(1'b1, 0);
    hdr(8'h01);
    for (int d = 8'h10; d <= 8'h15; d++) tx_q.push_back(8'(d));
    run_txn(1'b1, 0);
    hdr(8'h00); tx_q.push_back(8'h77); run_txn(1'b0, 3);
    tx_q.delete(); tx_q.push_back(8'hFE); tx_q.push_back(8'h02); run_txn(1'b1, 0);

`ifdef I2C_MEM_WRITER_ADDR_PTR_EN
    tx_q.delete();
    tx_q.push_back(8'hFE); tx_q.push_back(8'h00); tx_q.push_back(8'h7E);
    tx_q.push_back(8'h01); tx_q.push_back(8'h02);
    run_txn(1'b1, 0);
    tx_q.delete();
    tx_q.push_back(8'hFE); tx_q.push_back(8'h01); tx_q.push_back(8'hFF);
    tx_q.push_back(8'h03); tx_q.push_back(8'h04);
    run_txn(1'b1, 0);
`endif

    bus_open = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tx_q.delete();
      t = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFE;
      tx_q.push_back(t);
      tx_q.push_back(8'($urandom_range(0, 2)));
      if (PTR_EN) begin
        t = $urandom_range(0, 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
        tx_q.push_back(t);
      end
      for (int d = 0; d < int'($urandom_range(0, 5)); d++) tx_q.push_back(8'($urandom_range(0, 255)));
      stop_end = ($urandom_range(0, 3) != 0);
      run_txn(stop_end, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
      bus_open = !stop_end;
    end
    if (bus_open) bus_stop();

    txn_begin();
    send_byte(8'hFE, 1'b0);
    send_byte(8'h01, 1'b0);
`ifdef I2C_MEM_WRITER_ADDR_PTR_EN
    send_byte(8'h00, 1'b0);
`endif
    send_byte(8'h33, 1'b1);
    bus_stop();

    hdr(8'h01); tx_q.push_back(8'h5A); tx_q.push_back(8'hC3); run_txn(1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
